// File: rtl/qam_mapper_stream.sv
// -----------------------------------------------------------------------------
// qam_mapper_stream
//
// Streaming QAM symbol mapper. Accepts DATA_W-bit payload words over a
// valid/ready handshake, slices each word MSB-first into k-bit symbols
// (k chosen per word by qam) and emits one signed {I, Q} constellation point
// per cycle with downstream backpressure. Trailing DATA_W mod k bits of a
// word are discarded.
//
// Parameters
//   DATA_W : payload word width in bits (>= 8)
//   IQ_W   : width of each signed I and Q sample (>= 4)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   signal_in  in   payload word, first symbol taken from the MSBs
//   in_valid   in   signal_in valid
//   ready      out  mapper can accept a word this cycle
//   qam        in   0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM, 4 256QAM, 5-7 invalid
//   signal_out out  {I, Q}, each IQ_W-bit two's complement
//   valid      out  signal_out holds a valid symbol
//   out_ready  in   downstream accepts the symbol
//   last       out  current symbol is the final symbol of its word
//   error      out  one-cycle pulse after a word is accepted with invalid qam
//
// Build option
//   GRAY_MAP_EN : when defined, each axis index is Gray-decoded before the
//                 amplitude calculation (Gray-coded constellation). BPSK and
//                 QPSK are unaffected.
// -----------------------------------------------------------------------------
module qam_mapper_stream #(
  parameter int DATA_W = 32,
  parameter int IQ_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   signal_in,
  input  logic                in_valid,
  output logic                ready,
  input  logic [2:0]          qam,
  output logic [2*IQ_W-1:0]   signal_out,
  output logic                valid,
  input  logic                out_ready,
  output logic                last,
  output logic                error
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MAX_I = (2 ** (IQ_W - 1)) - 1;

  // Per-mode amplitude steps, resolved at elaboration time.
  localparam logic [IQ_W-1:0] STEP_1  = IQ_W'(MAX_I / 1);
  localparam logic [IQ_W-1:0] STEP_3  = IQ_W'(MAX_I / 3);
  localparam logic [IQ_W-1:0] STEP_7  = IQ_W'(MAX_I / 7);
  localparam logic [IQ_W-1:0] STEP_15 = IQ_W'(MAX_I / 15);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    MODE_BPSK  = 3'd0,
    MODE_QPSK  = 3'd1,
    MODE_16QAM = 3'd2,
    MODE_64QAM = 3'd3,
    MODE_256QAM = 3'd4
  } mode_t;

  state_t              state;
  state_t              state_next;
  mode_t               mode;
  logic [DATA_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    count;
  logic                error_q;

  logic                accept;
  logic                qam_ok;
  logic                fire;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] bits_per_symbol(input mode_t m);
    case (m)
      MODE_BPSK:   return 4'd1;
      MODE_QPSK:   return 4'd2;
      MODE_16QAM:  return 4'd4;
      MODE_64QAM:  return 4'd6;
      default:     return 4'd8;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] symbols_per_word(input logic [2:0] q);
    case (q)
      3'd0:    return CNT_W'(DATA_W / 1);
      3'd1:    return CNT_W'(DATA_W / 2);
      3'd2:    return CNT_W'(DATA_W / 4);
      3'd3:    return CNT_W'(DATA_W / 6);
      default: return CNT_W'(DATA_W / 8);
    endcase
  endfunction

  // (2n - span) * step, where span = 2^m - 1. |2n - span| <= span, so the
  // product never exceeds MAX and fits IQ_W bits without saturation.
  function automatic logic [IQ_W-1:0] axis_amp(input logic [3:0]      n,
                                                input logic [3:0]      span,
                                                input logic [IQ_W-1:0] step);
    logic signed [5:0]      lvl;
    logic signed [IQ_W+5:0] prod;
    lvl  = $signed({1'b0, n, 1'b0}) - $signed({2'b00, span});
    prod = (IQ_W + 6)'(lvl) * $signed({6'b0, step});
    return prod[IQ_W-1:0];
  endfunction

`ifdef GRAY_MAP_EN
  // Zero-extended Gray codes decode identically, so one 4-bit decoder serves
  // every axis width.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign qam_ok = (qam <= 3'd4);
  assign ready  = (state == IDLE) && !rst;
  assign valid  = (state == RUN);
  assign accept = in_valid && ready;
  assign fire   = valid && out_ready;
  assign last   = valid && (count == CNT_W'(1));
  assign error  = error_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && qam_ok)                  state_next = RUN;
      RUN:  if (fire && (count == CNT_W'(1)))      state_next = IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      count     <= '0;
      mode      <= MODE_BPSK;
      error_q   <= 1'b0;
    end else begin
      error_q <= accept && !qam_ok;
      if (accept && qam_ok) begin
        shift_reg <= signal_in;
        count     <= symbols_per_word(qam);
        mode      <= mode_t'(qam);
      end else if (fire) begin
        shift_reg <= shift_reg << bits_per_symbol(mode);
        count     <= count - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Constellation mapping
  // ---------------------------------------------------------------------------
  logic [7:0]      top;
  logic [3:0]      n_i;
  logic [3:0]      n_q;
  logic [3:0]      span;
  logic [IQ_W-1:0] step;
  logic            q_zero;
  logic [IQ_W-1:0] i_amp;
  logic [IQ_W-1:0] q_amp;

  assign top = shift_reg[DATA_W-1 -: 8];

  // BPSK reuses the single-bit-per-axis path: (2b - 1) * MAX on I, Q forced 0.
  always_comb begin
    n_i    = {3'b000, top[7]};
    n_q    = {3'b000, top[6]};
    span   = 4'd1;
    step   = STEP_1;
    q_zero = 1'b0;
    case (mode)
      MODE_BPSK: begin
        q_zero = 1'b1;
      end
      MODE_QPSK: begin
        n_i = {3'b000, top[7]};
        n_q = {3'b000, top[6]};
      end
      MODE_16QAM: begin
        n_i  = {2'b00, top[7:6]};
        n_q  = {2'b00, top[5:4]};
        span = 4'd3;
        step = STEP_3;
      end
      MODE_64QAM: begin
        n_i  = {1'b0, top[7:5]};
        n_q  = {1'b0, top[4:2]};
        span = 4'd7;
        step = STEP_7;
      end
      default: begin
        n_i  = top[7:4];
        n_q  = top[3:0];
        span = 4'd15;
        step = STEP_15;
      end
    endcase
  end

  always_comb begin
`ifdef GRAY_MAP_EN
    i_amp = axis_amp(gray2bin(n_i), span, step);
    q_amp = q_zero ? '0 : axis_amp(gray2bin(n_q), span, step);
`else
    i_amp = axis_amp(n_i, span, step);
    q_amp = q_zero ? '0 : axis_amp(n_q, span, step);
`endif
  end

  // Output is zero whenever no symbol is presented.
  assign signal_out = valid ? {i_amp, q_amp} : '0;

endmodule
